// File: rtl/wishbone_reg_subordinate.sv
// Wishbone classic-cycle register bank: NUM_REGS r/w words plus one read-only status word.
// Define WB_SUB_ERR_EN to terminate misses and status writes with ERR_O instead of ACK_O.
module wishbone_reg_subordinate #(
    parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
    parameter int          NUM_REGS    = 8,
    parameter int          WAIT_CYCLES = 2
) (
    input  logic                     CLK,
    input  logic                     nRST,
    input  logic [31:0]              ADR_I,
    input  logic [31:0]              DAT_I,
    input  logic [3:0]               SEL_I,
    input  logic                     WE_I,
    input  logic                     STB_I,
    input  logic                     CYC_I,
    input  logic [31:0]              STATUS_I,
    output logic [31:0]              DAT_O,
    output logic                     ACK_O,
`ifdef WB_SUB_ERR_EN
    output logic                     ERR_O,
`endif
    output logic [32*NUM_REGS-1:0]   REGS_O
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    localparam logic [31:0] LP_SPAN = 32'(4 * NUM_REGS);
    localparam logic [31:0] LP_STAT = BASE_ADDR + LP_SPAN;

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_adr;
    logic [31:0] r_dat;
    logic [3:0]  r_sel;
    logic        r_we;
    logic [3:0]  r_cnt;
    logic [31:0] r_regs [NUM_REGS];
    logic        r_ack;
    logic [31:0] r_rdat;

    logic        w_req;
    logic        w_enter;
    logic [31:0] w_adr;
    logic [31:0] w_dat;
    logic [3:0]  w_sel;
    logic        w_we;
    logic [31:0] w_off;
    logic        w_hit;
    logic        w_stat;
    logic [31:0] w_rd;

    assign w_req = CYC_I & STB_I;

    // With zero wait states the commit edge is the sample edge, so use the live bus.
    assign w_adr = (r_state == S_IDLE) ? ADR_I : r_adr;
    assign w_dat = (r_state == S_IDLE) ? DAT_I : r_dat;
    assign w_sel = (r_state == S_IDLE) ? SEL_I : r_sel;
    assign w_we  = (r_state == S_IDLE) ? WE_I  : r_we;

    assign w_enter = (r_state == S_IDLE && w_req && WAIT_CYCLES == 0)
                   || (r_state == S_WAIT && CYC_I && r_cnt == 4'd1);

    assign w_off  = w_adr - BASE_ADDR;
    assign w_hit  = (w_off[1:0] == 2'b00) && (w_off < LP_SPAN);
    assign w_stat = (w_adr == LP_STAT);

`ifdef WB_SUB_ERR_EN
    logic w_err;
    logic r_err;
    assign w_err = !w_hit && !(w_stat && !w_we);
    assign ERR_O = r_err;
`endif

    always_comb begin
        w_rd = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (w_hit && w_off[31:2] == 30'(k)) begin
                w_rd = r_regs[k];
            end
        end
        if (w_stat) begin
            w_rd = STATUS_I;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    w_next = (WAIT_CYCLES > 0) ? S_WAIT : S_RESP;
                end
            end
            S_WAIT: begin
                if (!CYC_I) begin
                    w_next = S_IDLE;
                end else if (r_cnt == 4'd1) begin
                    w_next = S_RESP;
                end
            end
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state <= S_IDLE;
            r_adr   <= '0;
            r_dat   <= '0;
            r_sel   <= '0;
            r_we    <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && w_req) begin
                r_adr <= ADR_I;
                r_dat <= DAT_I;
                r_sel <= SEL_I;
                r_we  <= WE_I;
                r_cnt <= 4'(WAIT_CYCLES);
            end else if (r_state == S_WAIT) begin
                r_cnt <= CYC_I ? r_cnt - 4'd1 : 4'd0;
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                r_regs[k] <= '0;
            end
        end else if (w_enter && w_we && w_hit) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                if (w_off[31:2] == 30'(k)) begin
                    for (int n = 0; n < 4; n++) begin
                        if (w_sel[n]) begin
                            r_regs[k][8*n +: 8] <= w_dat[8*n +: 8];
                        end
                    end
                end
            end
        end
    end

    // Response flops are high only during the single RESP cycle.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_ack  <= 1'b0;
            r_rdat <= '0;
`ifdef WB_SUB_ERR_EN
            r_err  <= 1'b0;
`endif
        end else begin
            r_ack  <= 1'b0;
            r_rdat <= '0;
`ifdef WB_SUB_ERR_EN
            r_err  <= 1'b0;
            if (w_enter) begin
                if (w_err) begin
                    r_err <= 1'b1;
                end else begin
                    r_ack <= 1'b1;
                    if (!w_we) begin
                        r_rdat <= w_rd;
                    end
                end
            end
`else
            if (w_enter) begin
                r_ack <= 1'b1;
                if (!w_we) begin
                    r_rdat <= w_rd;
                end
            end
`endif
        end
    end

    assign ACK_O = r_ack;
    assign DAT_O = r_rdat;

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs
        assign REGS_O[32*g +: 32] = r_regs[g];
    end

endmodule
